// File: rtl/ifu_pkg.sv
// Shared types for the instruction prefetch unit: FIFO entry layout, FSM states, PC step
// and a saturating counter helper used by the optional IFU_PERF_CNT_EN counters.
package ifu_pkg;

  localparam int IFU_AW  = 32;
  localparam int IFU_DW  = 32;
  localparam int PC_STEP = IFU_DW / 8;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    ERR_STOP = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_AW-1:0] pc;
    logic [IFU_DW-1:0] instr;
    logic              err;
  } ifu_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous in-order FIFO of packed fetch entries with flush; head is read combinationally
// from storage, so a push becomes visible the cycle after it is written.
module ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Successor-PC prefetch unit: credit-limited request issue, in-order response FIFO, jump flush
// with stale-response discard. IFU_PERF_CNT_EN adds saturating fetch/starve/flush counters.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_fetch_en,
  input  logic            i_jump_valid,
  input  logic [AW-1:0]   i_jump_pc,
  input  logic            i_holding,
  output logic            o_ifu_vrb_cmd_valid,
  input  logic            i_ifu_vrb_cmd_ready,
  output logic [AW-1:0]   o_ifu_vrb_cmd_addr,
  output logic            o_ifu_vrb_cmd_read,
  output logic [DW-1:0]   o_ifu_vrb_cmd_wdata,
  output logic [DW/8-1:0] o_ifu_vrb_cmd_wmask,
  input  logic            i_ifu_vrb_rsp_valid,
  input  logic            i_ifu_vrb_rsp_err,
  input  logic [DW-1:0]   i_ifu_vrb_rsp_rdata,
  output logic            o_instr_valid,
  output logic [AW-1:0]   o_pc,
  output logic [DW-1:0]   o_instr,
  output logic            o_instr_err,
  output logic            o_holding
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     o_perf_fetch_cnt,
  output logic [31:0]     o_perf_starve_cnt,
  output logic [31:0]     o_perf_flush_cnt
`endif
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam int            EW      = AW + DW + 1;
  localparam logic [AW-1:0] STEP    = AW'(DW / 8);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  ifu_state_e    r_state;
  ifu_state_e    w_state_nxt;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit_used;
  logic          w_cmd_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_push_data;
  logic [EW-1:0] w_head;

  // FIFO slots are reserved at issue time, so a response can never find the FIFO full.
  assign w_credit_used       = {1'b0, r_outstanding} + {1'b0, w_count};
  assign o_ifu_vrb_cmd_valid = (r_state == RUN) && i_fetch_en && !i_jump_valid &&
                               (w_credit_used < DEPTH_C);
  assign o_ifu_vrb_cmd_addr  = r_fetch_pc;
  assign o_ifu_vrb_cmd_read  = 1'b1;
  assign o_ifu_vrb_cmd_wdata = '0;
  assign o_ifu_vrb_cmd_wmask = '0;
  assign w_cmd_fire          = o_ifu_vrb_cmd_valid && i_ifu_vrb_cmd_ready;

  assign w_push      = i_ifu_vrb_rsp_valid && !i_jump_valid && (r_discard == '0);
  assign w_pop       = !w_empty && !i_holding && !i_jump_valid;
  assign w_push_data = {r_rsp_pc, i_ifu_vrb_rsp_rdata, i_ifu_vrb_rsp_err};

  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_jump_valid),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign o_instr_valid                 = !w_empty;
  assign o_holding                     = w_empty;
  assign {o_pc, o_instr, o_instr_err}  = w_empty ? '0 : w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_jump_valid)                       w_state_nxt = RUN;
    else if (w_push && i_ifu_vrb_rsp_err)   w_state_nxt = ERR_STOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (i_jump_valid) begin
      // Everything still owed by the bus becomes stale; a response landing now is already gone.
      r_fetch_pc    <= i_jump_pc;
      r_rsp_pc      <= i_jump_pc;
      r_outstanding <= '0;
      r_discard     <= r_outstanding + r_discard - CW'(i_ifu_vrb_rsp_valid);
    end else begin
      if (w_cmd_fire) r_fetch_pc <= r_fetch_pc + STEP;
      if (w_push)     r_rsp_pc   <= r_rsp_pc + STEP;
      r_outstanding <= r_outstanding + CW'(w_cmd_fire) - CW'(w_push);
      if (i_ifu_vrb_rsp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_push && w_full && !w_pop));
      assert (!(w_push && (r_outstanding == '0)));
      assert (!(i_jump_valid && i_ifu_vrb_rsp_valid && (r_outstanding == '0) && (r_discard == '0)));
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_starve;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch  <= '0;
      r_perf_starve <= '0;
      r_perf_flush  <= '0;
    end else begin
      if (w_cmd_fire)                r_perf_fetch  <= sat_inc32(r_perf_fetch);
      if (!i_holding && w_empty)     r_perf_starve <= sat_inc32(r_perf_starve);
      if (i_jump_valid)              r_perf_flush  <= sat_inc32(r_perf_flush);
    end
  end

  assign o_perf_fetch_cnt  = r_perf_fetch;
  assign o_perf_starve_cnt = r_perf_starve;
  assign o_perf_flush_cnt  = r_perf_flush;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: per-cycle vector table plus hand sequences for jump,
// error stop, ready stall and PC wrap, driven by a 1-cycle in-order bus responder.
`timescale 1ns/1ps
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en, jump_valid, holding, cmd_ready;
  logic [31:0] jump_pc;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cmd_valid, cmd_read, instr_valid, instr_err, hold_o;
  logic [31:0] cmd_addr, cmd_wdata, o_pc, o_instr;
  logic [3:0]  cmd_wmask;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_starve, perf_flush;
`endif

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_fetch_en          (fetch_en),
    .i_jump_valid        (jump_valid),
    .i_jump_pc           (jump_pc),
    .i_holding           (holding),
    .o_ifu_vrb_cmd_valid (cmd_valid),
    .i_ifu_vrb_cmd_ready (cmd_ready),
    .o_ifu_vrb_cmd_addr  (cmd_addr),
    .o_ifu_vrb_cmd_read  (cmd_read),
    .o_ifu_vrb_cmd_wdata (cmd_wdata),
    .o_ifu_vrb_cmd_wmask (cmd_wmask),
    .i_ifu_vrb_rsp_valid (rsp_valid),
    .i_ifu_vrb_rsp_err   (rsp_err),
    .i_ifu_vrb_rsp_rdata (rsp_rdata),
    .o_instr_valid       (instr_valid),
    .o_pc                (o_pc),
    .o_instr             (o_instr),
    .o_instr_err         (instr_err),
    .o_holding           (hold_o)
`ifdef IFU_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt    (perf_fetch),
    .o_perf_starve_cnt   (perf_starve),
    .o_perf_flush_cnt    (perf_flush)
`endif
  );

  typedef struct packed {
    logic        en;
    logic        hold;
    logic        cv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } pop_t;

  int          checks = 0;
  int          errors = 0;
  int          n_acc, n_starve, n_jump;
  logic [31:0] q[$];
  pop_t        pops[$];
  bit          rsp_en, err_on;
  logic [31:0] err_addr;
  logic        s_cv, s_iv, s_err, s_hold;
  logic [31:0] s_addr, s_pc, s_instr;
  vec_t        tbl[19];

  function automatic vec_t mk(logic en, logic hold, logic cv, logic [31:0] addr,
                              logic iv, logic [31:0] pc);
    vec_t v;
    v.en = en; v.hold = hold; v.cv = cv; v.addr = addr; v.iv = iv; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_pc(int i);
    return (pops.size() > i) ? pops[i].pc : 32'hDEAD_BEEF;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_valid"}, cmd_valid, 0);
    chk({tag, " instr_valid"}, instr_valid, 0);
    chk({tag, " holding"}, hold_o, 1);
    chk({tag, " cmd_read"}, cmd_read, 1);
    chk({tag, " wdata"}, cmd_wdata, 0);
    chk({tag, " wmask"}, cmd_wmask, 0);
    chk({tag, " pc/instr/err"}, o_pc | o_instr | instr_err, 0);
  endtask

  task automatic do_reset();
    fetch_en = 0; jump_valid = 0; jump_pc = 0; holding = 0; cmd_ready = 1;
    rsp_valid = 0; rsp_err = 0; rsp_rdata = 0;
    rst_n = 0;
    q.delete(); pops.delete();
    rsp_en = 1; err_on = 0; err_addr = 0;
    n_acc = 0; n_starve = 0; n_jump = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // One clock: drive the responder, sample after settling, log traffic, advance past the edge.
  task automatic cycle();
    logic [31:0] a;
    if (rsp_en && q.size() > 0) begin
      a = q.pop_front();
      rsp_valid = 1; rsp_rdata = ~a; rsp_err = err_on && (a == err_addr);
    end else begin
      rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
    end
    #1;
    s_cv = cmd_valid; s_addr = cmd_addr; s_iv = instr_valid;
    s_pc = o_pc; s_instr = o_instr; s_err = instr_err; s_hold = hold_o;
    if (s_iv && !holding && !jump_valid) pops.push_back('{s_pc, s_instr, s_err});
    if (s_cv && cmd_ready) begin q.push_back(s_addr); n_acc++; end
    if (!holding && !s_iv) n_starve++;
    if (jump_valid) n_jump++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, 0, 1, 32'h00, 0, 32'h00);
    tbl[1]  = mk(1, 0, 1, 32'h04, 0, 32'h00);
    tbl[2]  = mk(1, 0, 1, 32'h08, 1, 32'h00);
    tbl[3]  = mk(1, 1, 1, 32'h0C, 1, 32'h04);
    tbl[4]  = mk(1, 1, 1, 32'h10, 1, 32'h04);
    tbl[5]  = mk(1, 1, 0, 32'h00, 1, 32'h04);
    tbl[6]  = mk(1, 1, 0, 32'h00, 1, 32'h04);
    tbl[7]  = mk(1, 0, 0, 32'h00, 1, 32'h04);
    tbl[8]  = mk(1, 0, 1, 32'h14, 1, 32'h08);
    tbl[9]  = mk(1, 0, 1, 32'h18, 1, 32'h0C);
    tbl[10] = mk(1, 0, 1, 32'h1C, 1, 32'h10);
    tbl[11] = mk(1, 0, 1, 32'h20, 1, 32'h14);
    tbl[12] = mk(0, 0, 0, 32'h00, 1, 32'h18);
    tbl[13] = mk(0, 0, 0, 32'h00, 1, 32'h1C);
    tbl[14] = mk(0, 0, 0, 32'h00, 1, 32'h20);
    tbl[15] = mk(0, 0, 0, 32'h00, 0, 32'h00);
    tbl[16] = mk(1, 0, 1, 32'h24, 0, 32'h00);
    tbl[17] = mk(1, 0, 1, 32'h28, 0, 32'h00);
    tbl[18] = mk(1, 0, 1, 32'h2C, 1, 32'h24);

    fetch_en = 0; jump_valid = 0; jump_pc = 0; holding = 0; cmd_ready = 1;
    rsp_valid = 0; rsp_err = 0; rsp_rdata = 0;
    #3;
    check_reset_outputs("reset");

    // Streaming, credit stall under holding, fetch_en gap.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      fetch_en = tbl[i].en;
      holding  = tbl[i].hold;
      cycle();
      chk($sformatf("t%0d cmd_valid", i), s_cv, tbl[i].cv);
      if (tbl[i].cv) chk($sformatf("t%0d cmd_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("t%0d instr_valid", i), s_iv, tbl[i].iv);
      chk($sformatf("t%0d holding", i), s_hold, !tbl[i].iv);
      if (tbl[i].iv) begin
        chk($sformatf("t%0d pc", i), s_pc, tbl[i].pc);
        chk($sformatf("t%0d instr", i), s_instr, ~tbl[i].pc);
      end
    end

    // Reset in the middle of traffic.
    fetch_en = 0;
    rst_n = 0;
    q.delete();
    #1;
    check_reset_outputs("midreset");
    do_reset();
    fetch_en = 1;
    cycle();
    chk("post-reset first addr", s_addr, 32'h0);
    chk("post-reset cmd_valid", s_cv, 1);

    // Jump with three in flight; the oldest response lands in the jump cycle.
    do_reset();
    fetch_en = 1; rsp_en = 0;
    repeat (3) cycle();
    fetch_en = 0;
    cycle();
    jump_valid = 1; jump_pc = 32'h100; rsp_en = 1; fetch_en = 1;
    pops.delete();
    cycle();
    chk("jump cycle cmd_valid", s_cv, 0);
    jump_valid = 0;
    cycle();
    chk("jump resume cmd_valid", s_cv, 1);
    chk("jump resume addr", s_addr, 32'h100);
    repeat (8) cycle();
    chk("jump first pc", pop_pc(0), 32'h100);
    chk("jump second pc", pop_pc(1), 32'h104);

    // Bus error on 0x8 stops issue until a jump.
    do_reset();
    err_on = 1; err_addr = 32'h8; fetch_en = 1;
    repeat (4) cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk($sformatf("errstop cmd_valid %0d", i), s_cv, 0);
    end
    chk("errstop drained entries", pops.size(), 4);
    chk("errstop pc2", pop_pc(2), 32'h8);
    chk("errstop err2", (pops.size() > 2) ? pops[2].err : 1'bx, 1);
    chk("errstop err1", (pops.size() > 1) ? pops[1].err : 1'bx, 0);
    chk("errstop pc3", pop_pc(3), 32'hC);
    err_on = 0;
    jump_valid = 1; jump_pc = 32'h40; pops.delete();
    cycle();
    chk("errjump cycle cmd_valid", s_cv, 0);
    jump_valid = 0;
    cycle();
    chk("errjump resume cmd_valid", s_cv, 1);
    chk("errjump resume addr", s_addr, 32'h40);
    repeat (4) cycle();
    chk("errjump first pc", pop_pc(0), 32'h40);

    // cmd_ready low for five cycles holds the address, then PC wrap.
    do_reset();
    fetch_en = 1;
    cycle();
    cmd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("stall cmd_valid %0d", i), s_cv, 1);
      chk($sformatf("stall addr %0d", i), s_addr, 32'h4);
    end
    cmd_ready = 1;
    repeat (6) cycle();
    fetch_en = 0;
    repeat (6) cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("stall order %0d", i), pop_pc(i), 32'(i * 4));
    pops.delete();
    jump_valid = 1; jump_pc = 32'hFFFF_FFF8; fetch_en = 1;
    cycle();
    jump_valid = 0;
    repeat (8) cycle();
    chk("wrap pc0", pop_pc(0), 32'hFFFF_FFF8);
    chk("wrap pc1", pop_pc(1), 32'hFFFF_FFFC);
    chk("wrap pc2", pop_pc(2), 32'h0);
    chk("wrap pc3", pop_pc(3), 32'h4);
    chk("wrap instr2", (pops.size() > 2) ? pops[2].instr : 32'hDEAD_BEEF, 32'hFFFF_FFFF);

`ifdef IFU_PERF_CNT_EN
    do_reset();
    fetch_en = 1;
    repeat (5) cycle();
    jump_valid = 1; jump_pc = 32'h200;
    cycle();
    jump_valid = 0;
    repeat (4) cycle();
    jump_valid = 1; jump_pc = 32'h300;
    cycle();
    jump_valid = 0; fetch_en = 0;
    repeat (4) cycle();
    chk("perf fetch", perf_fetch, 32'(n_acc));
    chk("perf starve", perf_starve, 32'(n_starve));
    chk("perf flush", perf_flush, 32'(n_jump));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
